pixel_window_crop: RTL

PIXEL_WINDOW_CROP -- requirements
Module: pixel_window_crop

---
 rtl/pixel_window_crop.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pixel_window_crop.sv
// Crops a rectangular window out of a raster pixel stream after dropping leading pixels.
// Optional macro CROP_PIXCOUNT_EN adds the pixCount output-beat counter.
module pixel_window_crop #(
  parameter int DATA_WIDTH        = 8,
  parameter int DISCARD_CNT_WIDTH = 8,
  parameter int X_RES_WIDTH       = 11,
  parameter int Y_RES_WIDTH       = 11
) (
  input  logic                         clk0,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DISCARD_CNT_WIDTH-1:0] inputDiscardCnt,
  input  logic [X_RES_WIDTH-1:0]       inXRes,
  input  logic [Y_RES_WIDTH-1:0]       inYRes,
  input  logic [X_RES_WIDTH-1:0]       cropLeft,
  input  logic [Y_RES_WIDTH-1:0]       cropTop,
  input  logic [X_RES_WIDTH-1:0]       cropXRes,
  input  logic [Y_RES_WIDTH-1:0]       cropYRes,
  input  logic [DATA_WIDTH-1:0]        dIn,
  input  logic                         dInValid,
  output logic                         nextDin,
  output logic [DATA_WIDTH-1:0]        dOut,
  output logic                         dOutValid,
  input  logic                         nextDout,
  output logic                         frameDone
`ifdef CROP_PIXCOUNT_EN
  ,
  output logic [2*X_RES_WIDTH-1:0]     pixCount
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [X_RES_WIDTH-1:0]       X_ONE = X_RES_WIDTH'(1);
  localparam logic [Y_RES_WIDTH-1:0]       Y_ONE = Y_RES_WIDTH'(1);
  localparam logic [DISCARD_CNT_WIDTH-1:0] D_ONE = DISCARD_CNT_WIDTH'(1);

  logic [1:0]                   state_q, state_d;
  logic [X_RES_WIDTH-1:0]       x_q, x_d;
  logic [Y_RES_WIDTH-1:0]       y_q, y_d;
  logic [DISCARD_CNT_WIDTH-1:0] disc_q, disc_d, cfg_disc_q, cfg_disc_d;
  logic [X_RES_WIDTH-1:0]       cfg_xres_q, cfg_xres_d, cfg_left_q, cfg_left_d, cfg_cxres_q, cfg_cxres_d;
  logic [Y_RES_WIDTH-1:0]       cfg_yres_q, cfg_yres_d, cfg_top_q, cfg_top_d, cfg_cyres_q, cfg_cyres_d;
  logic [DATA_WIDTH-1:0]        dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         frame_done_q, frame_done_d;
  logic                         rdy_s, in_xfer_s, out_xfer_s, in_win_s;
  logic [DISCARD_CNT_WIDTH-1:0] disc_inc_s;
  logic [X_RES_WIDTH:0]         x_hi_s;
  logic [Y_RES_WIDTH:0]         y_hi_s;

  // Window bounds are one bit wider so origin + size never wraps.
  assign x_hi_s   = {1'b0, cfg_left_q} + {1'b0, cfg_cxres_q};
  assign y_hi_s   = {1'b0, cfg_top_q} + {1'b0, cfg_cyres_q};
  assign in_win_s = (x_q >= cfg_left_q) && ({1'b0, x_q} <= x_hi_s) &&
                    (y_q >= cfg_top_q) && ({1'b0, y_q} <= y_hi_s);

  assign disc_inc_s = disc_q + D_ONE;
  assign nextDin    = rdy_s && !start;
  assign in_xfer_s  = dInValid && nextDin;
  assign out_xfer_s = dout_valid_q && nextDout;
  assign dOut       = dout_q;
  assign dOutValid  = dout_valid_q;
  assign frameDone  = frame_done_q;

  // Upstream ready per state; start masks it so a coincident beat is refused.
  always_comb begin
    rdy_s = 1'b0;
    case (state_q)
      ST_DISCARD: rdy_s = 1'b1;
      ST_ACTIVE:  rdy_s = !dout_valid_q || nextDout;
      default:    rdy_s = 1'b0;
    endcase
  end

  // Next-state logic for FSM, raster counters, config shadow and output register.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    disc_d       = disc_q;
    cfg_disc_d   = cfg_disc_q;
    cfg_xres_d   = cfg_xres_q;
    cfg_yres_d   = cfg_yres_q;
    cfg_left_d   = cfg_left_q;
    cfg_top_d    = cfg_top_q;
    cfg_cxres_d  = cfg_cxres_q;
    cfg_cyres_d  = cfg_cyres_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_done_d = 1'b0;
    if (start) begin
      cfg_disc_d   = inputDiscardCnt;
      cfg_xres_d   = inXRes;
      cfg_yres_d   = inYRes;
      cfg_left_d   = cropLeft;
      cfg_top_d    = cropTop;
      cfg_cxres_d  = cropXRes;
      cfg_cyres_d  = cropYRes;
      x_d          = {X_RES_WIDTH{1'b0}};
      y_d          = {Y_RES_WIDTH{1'b0}};
      disc_d       = {DISCARD_CNT_WIDTH{1'b0}};
      dout_d       = {DATA_WIDTH{1'b0}};
      dout_valid_d = 1'b0;
      if (inputDiscardCnt == {DISCARD_CNT_WIDTH{1'b0}}) begin
        state_d = ST_ACTIVE;
      end else begin
        state_d = ST_DISCARD;
      end
    end else begin
      if (out_xfer_s) begin
        dout_valid_d = 1'b0;
      end else begin
        dout_valid_d = dout_valid_q;
      end
      case (state_q)
        ST_DISCARD: begin
          if (in_xfer_s) begin
            disc_d = disc_inc_s;
            if (disc_inc_s == cfg_disc_q) begin
              state_d = ST_ACTIVE;
            end else begin
              state_d = ST_DISCARD;
            end
          end else begin
            disc_d = disc_q;
          end
        end
        ST_ACTIVE: begin
          if (in_xfer_s) begin
            if (in_win_s) begin
              dout_d       = dIn;
              dout_valid_d = 1'b1;
            end else begin
              dout_d = dout_q;
            end
            if (x_q == cfg_xres_q) begin
              x_d = {X_RES_WIDTH{1'b0}};
              if (y_q == cfg_yres_q) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
              end else begin
                y_d = y_q + Y_ONE;
              end
            end else begin
              x_d = x_q + X_ONE;
            end
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: begin
          state_d      = ST_IDLE;
          dout_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      x_q          <= {X_RES_WIDTH{1'b0}};
      y_q          <= {Y_RES_WIDTH{1'b0}};
      disc_q       <= {DISCARD_CNT_WIDTH{1'b0}};
      cfg_disc_q   <= {DISCARD_CNT_WIDTH{1'b0}};
      cfg_xres_q   <= {X_RES_WIDTH{1'b0}};
      cfg_yres_q   <= {Y_RES_WIDTH{1'b0}};
      cfg_left_q   <= {X_RES_WIDTH{1'b0}};
      cfg_top_q    <= {Y_RES_WIDTH{1'b0}};
      cfg_cxres_q  <= {X_RES_WIDTH{1'b0}};
      cfg_cyres_q  <= {Y_RES_WIDTH{1'b0}};
      dout_q       <= {DATA_WIDTH{1'b0}};
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      disc_q       <= disc_d;
      cfg_disc_q   <= cfg_disc_d;
      cfg_xres_q   <= cfg_xres_d;
      cfg_yres_q   <= cfg_yres_d;
      cfg_left_q   <= cfg_left_d;
      cfg_top_q    <= cfg_top_d;
      cfg_cxres_q  <= cfg_cxres_d;
      cfg_cyres_q  <= cfg_cyres_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef CROP_PIXCOUNT_EN
  logic [2*X_RES_WIDTH-1:0] pix_cnt_q;

  // Output-beat counter; start clears it and wins over a coincident transfer.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      pix_cnt_q <= {(2*X_RES_WIDTH){1'b0}};
    end else if (start) begin
      pix_cnt_q <= {(2*X_RES_WIDTH){1'b0}};
    end else if (out_xfer_s) begin
      pix_cnt_q <= pix_cnt_q + (2*X_RES_WIDTH)'(1);
    end else begin
      pix_cnt_q <= pix_cnt_q;
    end
  end

  assign pixCount = pix_cnt_q;
`endif

endmodule
